// File: rtl/branch_resolve_ctrl.sv
// Branch resolution and direction prediction: decodes B-type funct3, resolves taken/mispredict,
// and keeps a 2-bit saturating BHT plus saturating branch/mispredict statistics.
module branch_resolve_ctrl #(
  parameter int WIDTH       = 32,
  parameter int BHT_ENTRIES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             br_valid,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] pc,
  input  logic             pred_in,
  input  logic             brEq,
  input  logic             brLT,
  input  logic [WIDTH-1:0] fetch_pc,
  input  logic             clr_stats,
  output logic             brUn,
  output logic             taken,
  output logic             mispredict,
  output logic             illegal_br,
  output logic             pred_taken,
  output logic [WIDTH-1:0] br_count,
  output logic [WIDTH-1:0] mp_count
);

  localparam int IDX_BITS = $clog2(BHT_ENTRIES);

  logic [1:0]          bht_q [BHT_ENTRIES];
  logic [1:0]          bht_cur;
  logic [1:0]          bht_d;
  logic [IDX_BITS-1:0] upd_idx;
  logic [IDX_BITS-1:0] fetch_idx;
  logic [WIDTH-1:0]    br_count_q, br_count_d;
  logic [WIDTH-1:0]    mp_count_q, mp_count_d;
  logic                cond_met;
  logic                f3_illegal;
  logic                legal;
  logic                unused_addr_bits;

  // Word-aligned PCs: the two low bits carry no information for indexing.
  assign upd_idx   = pc[IDX_BITS+1:2];
  assign fetch_idx = fetch_pc[IDX_BITS+1:2];
  assign unused_addr_bits = ^{pc[WIDTH-1:IDX_BITS+2], pc[1:0],
                              fetch_pc[WIDTH-1:IDX_BITS+2], fetch_pc[1:0]};

  assign brUn = funct3[2] & funct3[1];

  always_comb begin
    cond_met   = 1'b0;
    f3_illegal = 1'b0;
    case (funct3)
      3'b000:  cond_met = brEq;
      3'b001:  cond_met = ~brEq;
      3'b100:  cond_met = brLT;
      3'b101:  cond_met = ~brLT;
      3'b110:  cond_met = brLT;
      3'b111:  cond_met = ~brLT;
      default: f3_illegal = 1'b1;
    endcase
  end

  assign illegal_br = br_valid & f3_illegal;
  assign legal      = br_valid & ~f3_illegal;
  assign taken      = legal & cond_met;
  assign mispredict = legal & (taken ^ pred_in);

  // Asynchronous read of the pre-update table, so same-index read-during-write returns old data.
  assign pred_taken = bht_q[fetch_idx][1];

  always_comb begin
    bht_cur = bht_q[upd_idx];
    bht_d   = bht_cur;
    if (taken) begin
      if (bht_cur != 2'b11) bht_d = bht_cur + 2'd1;
    end else begin
      if (bht_cur != 2'b00) bht_d = bht_cur - 2'd1;
    end
  end

  always_comb begin
    br_count_d = br_count_q;
    mp_count_d = mp_count_q;
    if (clr_stats) begin
      br_count_d = '0;
      mp_count_d = '0;
    end else begin
      if (legal && (br_count_q != '1)) br_count_d = br_count_q + WIDTH'(1);
      if (mispredict && (mp_count_q != '1)) mp_count_d = mp_count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
      br_count_q <= '0;
      mp_count_q <= '0;
    end else begin
      if (legal) bht_q[upd_idx] <= bht_d;
      br_count_q <= br_count_d;
      mp_count_q <= mp_count_d;
    end
  end

  assign br_count = br_count_q;
  assign mp_count = mp_count_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed self-checking bench for branch_resolve_ctrl: decode truth table, BHT saturation,
// aliasing, illegal funct3, stats clear, read-during-write and mid-stream reset.
module tb_branch_resolve_ctrl;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             br_valid;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] pc;
  logic             pred_in;
  logic             brEq;
  logic             brLT;
  logic [WIDTH-1:0] fetch_pc;
  logic             clr_stats;
  logic             brUn;
  logic             taken;
  logic             mispredict;
  logic             illegal_br;
  logic             pred_taken;
  logic [WIDTH-1:0] br_count;
  logic [WIDTH-1:0] mp_count;

  int n_cmp = 0;
  int n_err = 0;

  branch_resolve_ctrl #(.WIDTH(WIDTH), .BHT_ENTRIES(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .br_valid   (br_valid),
    .funct3     (funct3),
    .pc         (pc),
    .pred_in    (pred_in),
    .brEq       (brEq),
    .brLT       (brLT),
    .fetch_pc   (fetch_pc),
    .clr_stats  (clr_stats),
    .brUn       (brUn),
    .taken      (taken),
    .mispredict (mispredict),
    .illegal_br (illegal_br),
    .pred_taken (pred_taken),
    .br_count   (br_count),
    .mp_count   (mp_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] f3, input logic eq, input logic lt,
                       input logic pr, input logic [31:0] p, input logic [31:0] fp);
    br_valid = v;
    funct3   = f3;
    brEq     = eq;
    brLT     = lt;
    pred_in  = pr;
    pc       = p;
    fetch_pc = fp;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input string tag, input int br_exp, input int mp_exp);
    check({tag, "_br"}, br_count, 32'(br_exp));
    check({tag, "_mp"}, mp_count, 32'(mp_exp));
  endtask

  // Hand truth table: bit index = {brEq, brLT}
  logic [2:0] tt_f3  [6] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
  logic [3:0] tt_tk  [6] = '{4'b1100, 4'b0011, 4'b1010, 4'b0101, 4'b1010, 4'b0101};
  logic       tt_un  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic       sat_pred [4] = '{1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    rst = 1'b1;
    clr_stats = 1'b0;
    drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    rst = 1'b0;

    for (int a = 0; a <= 32'h3C; a += 4) begin
      fetch_pc = 32'(a);
      #1;
      check($sformatf("rst_pred_%0h", a), 32'(pred_taken), 0);
    end
    check_counts("rst_cnt", 0, 0);

    // Truth table under reset so nothing is recorded
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 4; j++) begin
        logic [3:0] tkv;
        tkv = tt_tk[i];
        drive(1'b1, tt_f3[i], j[1], j[0], 1'b0, 32'h80, 32'h0);
        check($sformatf("tt_taken_f%0d_%0d", tt_f3[i], j), 32'(taken), 32'(tkv[j]));
        check($sformatf("tt_mp_f%0d_%0d", tt_f3[i], j), 32'(mispredict), 32'(tkv[j]));
        check($sformatf("tt_brun_f%0d", tt_f3[i]), 32'(brUn), 32'(tt_un[i]));
        check($sformatf("tt_ill_f%0d", tt_f3[i]), 32'(illegal_br), 0);
      end
    end
    drive(1'b0, 3'b110, 1'b0, 1'b1, 1'b1, 32'h80, 32'h0);
    check("nv_taken", 32'(taken), 0);
    check("nv_mp", 32'(mispredict), 0);
    check("nv_brun", 32'(brUn), 1);
    tick();
    rst = 1'b0;
    check_counts("tt_cnt", 0, 0);

    drive(1'b1, 3'b110, 1'b0, 1'b1, 1'b0, 32'h80, 32'h0);
    check("bltu_brun", 32'(brUn), 1);
    check("bltu_taken", 32'(taken), 1);
    drive(1'b1, 3'b101, 1'b0, 1'b1, 1'b0, 32'h80, 32'h0);
    check("bge_brun", 32'(brUn), 0);
    check("bge_taken", 32'(taken), 0);
    drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // Saturation walk at 0x40 (index 0)
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 32'h40, 32'h40);
      check($sformatf("sat_up_mp%0d", k), 32'(mispredict), 1);
      tick();
      check($sformatf("sat_up_pred%0d", k), 32'(pred_taken), 1);
    end
    check_counts("sat_up_cnt", 3, 3);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 32'h40, 32'h40);
      check($sformatf("sat_dn_mp%0d", k), 32'(mispredict), 0);
      tick();
      check($sformatf("sat_dn_pred%0d", k), 32'(pred_taken), 32'(sat_pred[k]));
    end
    check_counts("sat_dn_cnt", 7, 3);
    // From 00 one taken update must still predict not-taken
    drive(1'b1, 3'b000, 1'b1, 1'b0, 1'b1, 32'h40, 32'h40);
    tick();
    check("sat_floor_pred", 32'(pred_taken), 0);
    check_counts("sat_floor_cnt", 8, 3);

    // Aliasing on index 1
    drive(1'b1, 3'b001, 1'b0, 1'b0, 1'b1, 32'h04, 32'h08);
    tick();
    tick();
    drive(1'b0, 3'b001, 1'b0, 1'b0, 1'b1, 32'h04, 32'h44);
    check("alias_44", 32'(pred_taken), 1);
    fetch_pc = 32'h04; #1;
    check("alias_04", 32'(pred_taken), 1);
    fetch_pc = 32'h84; #1;
    check("alias_84", 32'(pred_taken), 1);
    fetch_pc = 32'h08; #1;
    check("alias_08", 32'(pred_taken), 0);
    check_counts("alias_cnt", 10, 3);

    // Illegal funct3 against entry 0 (currently 01)
    drive(1'b1, 3'b010, 1'b1, 1'b1, 1'b1, 32'h40, 32'h40);
    check("ill010_flag", 32'(illegal_br), 1);
    check("ill010_taken", 32'(taken), 0);
    check("ill010_mp", 32'(mispredict), 0);
    tick();
    drive(1'b1, 3'b011, 1'b1, 1'b1, 1'b1, 32'h40, 32'h40);
    check("ill011_flag", 32'(illegal_br), 1);
    tick();
    drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h40, 32'h40);
    check("ill_pred", 32'(pred_taken), 0);
    check_counts("ill_cnt", 10, 3);

    // Clear with a legal mispredicted branch in the same cycle
    clr_stats = 1'b1;
    drive(1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 32'h40, 32'h40);
    tick();
    clr_stats = 1'b0;
    drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h40, 32'h40);
    check_counts("clr_cnt", 0, 0);
    check("clr_bht_pred", 32'(pred_taken), 1);

    // Read-during-write at 0x10 (index 4, entry 01)
    drive(1'b1, 3'b100, 1'b0, 1'b1, 1'b0, 32'h10, 32'h10);
    check("rdw_same_cycle", 32'(pred_taken), 0);
    tick();
    check("rdw_next_cycle", 32'(pred_taken), 1);
    check_counts("rdw_cnt", 1, 1);

    // Mid-stream reset discards the concurrent update
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, 3'b100, 1'b0, 1'b1, 1'b0, 32'h10, 32'h10);
    check("rst2_pred_10", 32'(pred_taken), 0);
    fetch_pc = 32'h04; #1;
    check("rst2_pred_04", 32'(pred_taken), 0);
    check_counts("rst2_cnt", 0, 0);
    drive(1'b1, 3'b100, 1'b0, 1'b1, 1'b1, 32'h10, 32'h10);
    tick();
    check("rst2_first_upd", 32'(pred_taken), 1);
    check_counts("rst2_upd_cnt", 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
